cr_ifu_fetch_sched: RTL and testbench

Fetch request scheduler for the IFU. It generates sequential word-aligned instruction fetch requests toward the ibus interface and throttles them against instruction-buffer free space and an outstanding-transaction limit. On IF cancel/redirect it restarts at the new PC, discards responses still in flight for the old stream, and flags an unaligned first fetch. Its qualified response valid and unalign flag drive the bypass and ibuf-push decisions in IF control.

---
 rtl/cr_ifu_fetch_pkg.sv | 20 ++
 rtl/cr_ifu_fetch_cnt.sv | 56 +++++
 rtl/cr_ifu_fetch_sched.sv | 113 +++++++++++
 tb/tb_cr_ifu_fetch_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_ifu_fetch_pkg.sv
// Shared definitions for the IFU fetch scheduler.
//   fetch_state_e : scheduler FSM state encoding
//   FETCH_STRIDE  : byte increment between sequential fetch words
//   outstd_w()    : width of a counter that holds 0..max_outstd
package cr_ifu_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_ERR  = 2'b11
  } fetch_state_e;

  localparam int unsigned FETCH_STRIDE = 4;

  function automatic int unsigned outstd_w(input int unsigned max_outstd);
    return $clog2(max_outstd + 1);
  endfunction

endpackage

// File: rtl/cr_ifu_fetch_cnt.sv
// Outstanding / discard transaction counters for the IFU fetch scheduler.
//   cpuclk, cpurst_b : clock, asynchronous active-low reset
//   redirect         : fetch stream restarts this cycle
//   accept           : a fetch request is accepted by the ibus this cycle
//   rsp_vld          : an ibus transaction completes this cycle
//   outstd_cnt       : accepted-but-unreturned transactions
//   discard_cnt      : in-flight transactions belonging to an abandoned stream
module cr_ifu_fetch_cnt
  import cr_ifu_fetch_pkg::*;
#(
  parameter  int unsigned MAX_OUTSTD = 2,
  localparam int unsigned CNT_W      = outstd_w(MAX_OUTSTD)
) (
  input  logic             cpuclk,
  input  logic             cpurst_b,
  input  logic             redirect,
  input  logic             accept,
  input  logic             rsp_vld,
  output logic [CNT_W-1:0] outstd_cnt,
  output logic [CNT_W-1:0] discard_cnt
);

  logic [CNT_W-1:0] outstd_next;
  logic [CNT_W-1:0] discard_next;

  always_comb begin
    outstd_next = outstd_cnt;
    case ({accept, rsp_vld})
      2'b10:   outstd_next = outstd_cnt + CNT_W'(1);
      // A response with nothing outstanding is illegal; hold at zero.
      2'b01:   if (outstd_cnt != '0) outstd_next = outstd_cnt - CNT_W'(1);
      default: outstd_next = outstd_cnt;
    endcase
  end

  // On redirect everything still in flight (after this cycle's traffic)
  // belongs to the old stream and must be dropped when it returns.
  always_comb begin
    discard_next = discard_cnt;
    if (redirect)
      discard_next = outstd_next;
    else if (rsp_vld && discard_cnt != '0)
      discard_next = discard_cnt - CNT_W'(1);
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      outstd_cnt  <= '0;
      discard_cnt <= '0;
    end else begin
      outstd_cnt  <= outstd_next;
      discard_cnt <= discard_next;
    end
  end

endmodule

// File: rtl/cr_ifu_fetch_sched.sv
// IFU fetch request scheduler.
// Issues sequential word-aligned fetch requests to the ibus, throttled by
// ibuf free space and an outstanding-transaction limit; restarts on redirect
// and qualifies responses so that old-stream returns are dropped.
//   cpuclk, cpurst_b     : clock, asynchronous active-low reset
//   iu_ifu_redirect_vld  : new fetch PC valid (coincides with IF cancel)
//   iu_ifu_redirect_pc   : new fetch PC, bit0 ignored
//   iu_ifu_fetch_hold    : suspend new requests
//   ibuf_fetch_free_cnt  : free ibuf words, excluding in-flight fetches
//   fetch_req_vld/addr   : request toward ibus (combinational valid)
//   fetch_req_rdy        : ibus accepts request
//   fetch_rsp_vld/err    : ibus transaction complete / bus error
//   fetch_data_vld       : response belongs to the current stream
//   fetch_unalign        : first current-stream word after redirect, PC[1]=1
//   fetch_err_vld        : error on a current-stream response
//   fetch_outstd_empty   : no transaction outstanding
module cr_ifu_fetch_sched
  import cr_ifu_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MAX_OUTSTD = 2,
  parameter int unsigned FREE_W     = 3
) (
  input  logic              cpuclk,
  input  logic              cpurst_b,
  input  logic              iu_ifu_redirect_vld,
  input  logic [ADDR_W-1:0] iu_ifu_redirect_pc,
  input  logic              iu_ifu_fetch_hold,
  input  logic [FREE_W-1:0] ibuf_fetch_free_cnt,
  output logic              fetch_req_vld,
  output logic [ADDR_W-1:0] fetch_req_addr,
  input  logic              fetch_req_rdy,
  input  logic              fetch_rsp_vld,
  input  logic              fetch_rsp_err,
  output logic              fetch_data_vld,
  output logic              fetch_unalign,
  output logic              fetch_err_vld,
  output logic              fetch_outstd_empty
);

  localparam int unsigned CNT_W = outstd_w(MAX_OUTSTD);
  localparam int unsigned CMP_W = (FREE_W > CNT_W) ? FREE_W : CNT_W;

  fetch_state_e     state;
  logic [CNT_W-1:0] outstd_cnt;
  logic [CNT_W-1:0] discard_cnt;
  logic             first_flag;
  logic             unalign_pend;
  logic             accept;
  logic             stale;
  logic             rsp_cur;
  logic             pc0_unused;

  // Halfword offset is carried by unalign_pend; the byte bit has no meaning.
  assign pc0_unused = iu_ifu_redirect_pc[0];

  assign fetch_req_vld = (state == ST_RUN) && !iu_ifu_redirect_vld
                      && (outstd_cnt < CNT_W'(MAX_OUTSTD))
                      && (CMP_W'(ibuf_fetch_free_cnt) > CMP_W'(outstd_cnt));
  assign accept        = fetch_req_vld && fetch_req_rdy;

  assign stale              = (discard_cnt != '0) || iu_ifu_redirect_vld;
  assign rsp_cur            = fetch_rsp_vld && !stale;
  assign fetch_data_vld     = rsp_cur && !fetch_rsp_err;
  assign fetch_err_vld      = rsp_cur && fetch_rsp_err;
  assign fetch_unalign      = fetch_data_vld && first_flag && unalign_pend;
  assign fetch_outstd_empty = (outstd_cnt == '0);

  cr_ifu_fetch_cnt #(
    .MAX_OUTSTD (MAX_OUTSTD)
  ) u_cnt (
    .cpuclk      (cpuclk),
    .cpurst_b    (cpurst_b),
    .redirect    (iu_ifu_redirect_vld),
    .accept      (accept),
    .rsp_vld     (fetch_rsp_vld),
    .outstd_cnt  (outstd_cnt),
    .discard_cnt (discard_cnt)
  );

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state          <= ST_IDLE;
      fetch_req_addr <= '0;
      first_flag     <= 1'b0;
      unalign_pend   <= 1'b0;
    end else if (iu_ifu_redirect_vld) begin
      state          <= iu_ifu_fetch_hold ? ST_HOLD : ST_RUN;
      fetch_req_addr <= {iu_ifu_redirect_pc[ADDR_W-1:2], 2'b00};
      first_flag     <= 1'b1;
      unalign_pend   <= iu_ifu_redirect_pc[1];
    end else begin
      if (accept)
        fetch_req_addr <= fetch_req_addr + ADDR_W'(FETCH_STRIDE);
      if (rsp_cur)
        first_flag <= 1'b0;
      case (state)
        ST_RUN: begin
          if (fetch_err_vld)
            state <= ST_ERR;
          else if (iu_ifu_fetch_hold)
            state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!iu_ifu_fetch_hold)
            state <= ST_RUN;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_cr_ifu_fetch_sched.sv
module tb_cr_ifu_fetch_sched;

  localparam int MAXO = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_ERR = 3;

  logic        cpuclk = 1'b0;
  logic        cpurst_b;
  logic        redir;
  logic [31:0] pc;
  logic        hold;
  logic [2:0]  free;
  logic        req_vld;
  logic [31:0] req_addr;
  logic        rdy;
  logic        rsp;
  logic        err;
  logic        data_vld;
  logic        unal;
  logic        err_vld;
  logic        empty;

  cr_ifu_fetch_sched #(
    .ADDR_W     (32),
    .MAX_OUTSTD (MAXO),
    .FREE_W     (3)
  ) dut (
    .cpuclk              (cpuclk),
    .cpurst_b            (cpurst_b),
    .iu_ifu_redirect_vld (redir),
    .iu_ifu_redirect_pc  (pc),
    .iu_ifu_fetch_hold   (hold),
    .ibuf_fetch_free_cnt (free),
    .fetch_req_vld       (req_vld),
    .fetch_req_addr      (req_addr),
    .fetch_req_rdy       (rdy),
    .fetch_rsp_vld       (rsp),
    .fetch_rsp_err       (err),
    .fetch_data_vld      (data_vld),
    .fetch_unalign       (unal),
    .fetch_err_vld       (err_vld),
    .fetch_outstd_empty  (empty)
  );

  always #5 cpuclk = ~cpuclk;

  int total = 0;
  int bad   = 0;

  // Reference model: in-flight transactions are a FIFO of stream tags; a
  // response is current only if its tag matches the live stream.
  int          m_q[$];
  int          m_stream;
  int          m_mode;
  logic [31:0] m_addr;
  bit          m_first;
  bit          m_unal;
  bit          e_acc, e_cur, e_err;
  int          acc_cnt;

  typedef struct {
    logic        redir;
    logic [31:0] pc;
    logic        rdy;
    logic        rsp;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_data;
    logic        e_unal;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", nm, what, act, exp);
    end
  endtask

  task automatic drive(input bit r, input logic [31:0] p, input bit h,
                       input int f, input bit rd, input bit rs, input bit e);
    redir = r; pc = p; hold = h; free = 3'(f); rdy = rd; rsp = rs; err = e;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_stream = 0; m_mode = M_IDLE; m_addr = '0; m_first = 0; m_unal = 0;
  endtask

  task automatic sample_check(input string nm);
    bit e_req, stale, e_data, e_un;
    int nstale;
    @(negedge cpuclk);
    e_req  = (m_mode == M_RUN) && !redir && (m_q.size() < MAXO)
          && (int'(free) > m_q.size());
    stale  = redir || (m_q.size() > 0 && m_q[0] != m_stream);
    e_cur  = rsp && !stale;
    e_data = e_cur && !err;
    e_err  = e_cur && err;
    e_un   = e_data && m_first && m_unal;
    e_acc  = e_req && rdy;
    nstale = 0;
    foreach (m_q[i]) if (m_q[i] != m_stream) nstale++;
    chk(nm, "req_vld",  {31'd0, req_vld},  {31'd0, e_req});
    chk(nm, "req_addr", req_addr,          m_addr);
    chk(nm, "data_vld", {31'd0, data_vld}, {31'd0, e_data});
    chk(nm, "unalign",  {31'd0, unal},     {31'd0, e_un});
    chk(nm, "err_vld",  {31'd0, err_vld},  {31'd0, e_err});
    chk(nm, "empty",    {31'd0, empty},    {31'd0, m_q.size() == 0});
    chk(nm, "outstd",   32'(dut.outstd_cnt),  32'(m_q.size()));
    chk(nm, "discard",  32'(dut.discard_cnt), 32'(nstale));
    if (rsp) chk(nm, "rsp_when_empty", {31'd0, empty}, 32'd0);
  endtask

  task automatic advance();
    @(posedge cpuclk);
    if (e_acc) acc_cnt++;
    if (rsp && m_q.size() > 0) void'(m_q.pop_front());
    if (e_acc) m_q.push_back(m_stream);
    if (redir) begin
      m_stream++;
      m_addr  = {pc[31:2], 2'b00};
      m_first = 1;
      m_unal  = pc[1];
      m_mode  = hold ? M_HOLD : M_RUN;
    end else begin
      if (e_acc) m_addr = m_addr + 32'd4;
      if (e_cur) m_first = 0;
      if (m_mode == M_RUN) begin
        if (e_err) m_mode = M_ERR;
        else if (hold) m_mode = M_HOLD;
      end else if (m_mode == M_HOLD && !hold) m_mode = M_RUN;
    end
    #1;
  endtask

  task automatic cyc(input string nm);
    sample_check(nm);
    advance();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'h000, 1'b1, 1'b1, 1'b1, 32'h104, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 32'h000, 1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 32'h000, 1'b1, 1'b1, 1'b1, 32'h10C, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 32'h202, 1'b1, 1'b1, 1'b0, 32'h110, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 32'h000, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 32'h000, 1'b1, 1'b1, 1'b1, 32'h204, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 32'h000, 1'b1, 1'b1, 1'b1, 32'h208, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 32'h000, 1'b0, 1'b1, 1'b1, 32'h20C, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 32'h000, 1'b0, 1'b0, 1'b1, 32'h20C, 1'b0, 1'b0};

    cpurst_b = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    acc_cnt = 0;
    #2;
    chk("reset", "req_vld",  {31'd0, req_vld},  32'd0);
    chk("reset", "req_addr", req_addr,          32'd0);
    chk("reset", "data_vld", {31'd0, data_vld}, 32'd0);
    chk("reset", "unalign",  {31'd0, unal},     32'd0);
    chk("reset", "err_vld",  {31'd0, err_vld},  32'd0);
    chk("reset", "empty",    {31'd0, empty},    32'd1);
    @(negedge cpuclk);
    cpurst_b = 1'b1;
    @(posedge cpuclk); #1;

    // Sequential stream at 0x100, then unaligned redirect to 0x202.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].redir, tbl[i].pc, 0, 4, tbl[i].rdy, tbl[i].rsp, 0);
      sample_check($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d", i), "t_req",  {31'd0, req_vld},  {31'd0, tbl[i].e_req});
      chk($sformatf("tbl%0d", i), "t_addr", req_addr,          tbl[i].e_addr);
      chk($sformatf("tbl%0d", i), "t_data", {31'd0, data_vld}, {31'd0, tbl[i].e_data});
      chk($sformatf("tbl%0d", i), "t_unal", {31'd0, unal},     {31'd0, tbl[i].e_unal});
      advance();
    end

    // Two outstanding, redirect to 0x400: both old returns dropped.
    drive(0, 0, 0, 4, 1, 0, 0); cyc("wh_acc0");
    drive(0, 0, 0, 4, 1, 0, 0); cyc("wh_acc1");
    drive(0, 0, 0, 4, 1, 0, 0); sample_check("wh_full");
    chk("wh_full", "max_req", {31'd0, req_vld}, 32'd0); advance();
    drive(1, 32'h400, 0, 4, 1, 0, 0); sample_check("wh_redir");
    chk("wh_redir", "req_forced_low", {31'd0, req_vld}, 32'd0); advance();
    drive(0, 0, 0, 4, 0, 1, 0); sample_check("wh_old0");
    chk("wh_old0", "drop", {31'd0, data_vld}, 32'd0);
    chk("wh_old0", "disc", 32'(dut.discard_cnt), 32'd2); advance();
    drive(0, 0, 0, 4, 0, 1, 0); sample_check("wh_old1");
    chk("wh_old1", "drop", {31'd0, data_vld}, 32'd0);
    chk("wh_old1", "disc", 32'(dut.discard_cnt), 32'd1); advance();
    drive(0, 0, 0, 4, 1, 0, 0); sample_check("wh_new");
    chk("wh_new", "addr", req_addr, 32'h400); advance();
    drive(0, 0, 0, 4, 0, 1, 0); sample_check("wh_rsp");
    chk("wh_rsp", "data", {31'd0, data_vld}, 32'd1); advance();

    // Redirect coinciding with a response while two are outstanding.
    drive(0, 0, 0, 4, 1, 0, 0); cyc("cr_acc0");
    drive(0, 0, 0, 4, 1, 0, 0); cyc("cr_acc1");
    drive(1, 32'h500, 0, 4, 1, 1, 0); sample_check("cr_redir");
    chk("cr_redir", "stale", {31'd0, data_vld}, 32'd0); advance();
    drive(0, 0, 0, 4, 0, 1, 0); sample_check("cr_after");
    chk("cr_after", "disc", 32'(dut.discard_cnt), 32'd1);
    chk("cr_after", "drop", {31'd0, data_vld}, 32'd0); advance();

    // Free space of one word: exactly one accept while nothing returns.
    acc_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1, 1, 0, 0); cyc("free1");
    end
    chk("free1", "accepts", 32'(acc_cnt), 32'd1);
    drive(0, 0, 0, 1, 0, 1, 0); cyc("free1_rsp");

    // Hold mid-stream: in-flight responses qualify, no new accepts.
    drive(0, 0, 0, 4, 1, 0, 0); cyc("hd_acc0");
    drive(0, 0, 1, 4, 1, 0, 0); cyc("hd_acc1");
    acc_cnt = 0;
    drive(0, 0, 1, 4, 1, 1, 0); sample_check("hd_rsp0");
    chk("hd_rsp0", "data", {31'd0, data_vld}, 32'd1); advance();
    drive(0, 0, 1, 4, 1, 1, 0); sample_check("hd_rsp1");
    chk("hd_rsp1", "data", {31'd0, data_vld}, 32'd1); advance();
    drive(0, 0, 1, 4, 1, 0, 0); cyc("hd_idle");
    drive(0, 0, 0, 4, 1, 0, 0); cyc("hd_release");
    chk("hold", "accepts", 32'(acc_cnt), 32'd0);
    drive(0, 0, 0, 4, 1, 0, 0); sample_check("hd_resume");
    chk("hd_resume", "addr", req_addr, 32'h50C); advance();

    // Bus error on a current-stream response.
    drive(0, 0, 0, 4, 0, 1, 1); sample_check("er_rsp");
    chk("er_rsp", "err_vld", {31'd0, err_vld}, 32'd1); advance();
    drive(0, 0, 0, 4, 1, 0, 0); sample_check("er_wait0");
    chk("er_wait0", "err_pulse", {31'd0, err_vld}, 32'd0);
    chk("er_wait0", "no_req", {31'd0, req_vld}, 32'd0); advance();
    drive(0, 0, 0, 4, 1, 0, 0); cyc("er_wait1");
    drive(1, 32'h80, 0, 4, 1, 0, 0); cyc("er_redir");
    drive(0, 0, 0, 4, 1, 0, 0); sample_check("er_resume");
    chk("er_resume", "addr", req_addr, 32'h80);
    chk("er_resume", "req", {31'd0, req_vld}, 32'd1); advance();
    drive(0, 0, 0, 4, 0, 1, 0); cyc("er_data");

    // Randomized traffic against the reference model.
    hold = 0;
    for (int n = 0; n < 3000; n++) begin
      bit r, rs;
      r  = ($urandom_range(0, 15) == 0);
      rs = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) hold = ~hold;
      drive(r, $urandom, hold, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            rs, rs && ($urandom_range(0, 9) == 0));
      cyc("rnd");
    end

    // Reset in the middle of operation.
    drive(1, 32'h40, 0, 4, 1, 0, 0); cyc("pre_rst");
    drive(0, 0, 0, 4, 1, 0, 0); cyc("pre_rst_acc");
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 cpurst_b = 1'b0;
    #1;
    model_reset();
    chk("midrst", "empty", {31'd0, empty},    32'd1);
    chk("midrst", "addr",  req_addr,          32'd0);
    chk("midrst", "req",   {31'd0, req_vld},  32'd0);
    @(negedge cpuclk);
    cpurst_b = 1'b1;
    @(posedge cpuclk); #1;
    drive(0, 0, 0, 4, 1, 0, 0); cyc("post_idle");
    drive(1, 32'h1FE, 0, 4, 1, 0, 0); cyc("post_redir");
    drive(0, 0, 0, 4, 1, 0, 0); cyc("post_acc");
    drive(0, 0, 0, 4, 0, 1, 0); sample_check("post_rsp");
    chk("post_rsp", "unal", {31'd0, unal}, 32'd1); advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
